// File: rtl/mem_ctrl.sv
// Shared byte-wide RAM port controller: arbitrates instruction fetch against
// ex_ls and serialises 1/2/4-byte little-endian accesses into byte cycles.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_finish,
    output logic [31:0] if_data,
    input  logic        en_ls,
    input  logic        r_nw_in,
    input  logic [31:0] ls_addr,
    input  logic [7:0]  ls_size,
    input  logic [31:0] ls_data_in,
    output logic        finish,
    output logic [31:0] ls_data_out,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    localparam logic READ_SIGNAL = 1'b1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    owner_t      last_owner, last_owner_nxt;
    logic        is_read, is_read_nxt;
    logic [31:0] base, base_nxt;
    logic [2:0]  nbytes, nbytes_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [31:0] asm_q, asm_nxt;
    logic [31:0] ram_addr_nxt;
    logic        ram_wr_nxt;
    logic [7:0]  ram_dout_nxt;
    logic        finish_nxt, if_finish_nxt;
    logic [31:0] ls_data_out_nxt, if_data_nxt;
    logic        grant_ls;
    logic        xfer_end;
    logic [2:0]  cnt_inc;
    logic [1:0]  cap_idx;

    function automatic logic [2:0] size_decode(input logic [7:0] sz);
        if (sz == 8'd1)      return 3'd1;
        else if (sz == 8'd2) return 3'd2;
        else                 return 3'd4;
    endfunction

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_owner_nxt  = last_owner;
        is_read_nxt     = is_read;
        base_nxt        = base;
        nbytes_nxt      = nbytes;
        cnt_nxt         = cnt;
        wdata_nxt       = wdata;
        asm_nxt         = asm_q;
        ram_addr_nxt    = ram_addr;
        ram_wr_nxt      = 1'b0;
        ram_dout_nxt    = ram_dout;
        finish_nxt      = 1'b0;
        if_finish_nxt   = 1'b0;
        ls_data_out_nxt = ls_data_out;
        if_data_nxt     = if_data;
        grant_ls        = 1'b0;
        xfer_end        = 1'b0;
        cnt_inc         = cnt + 3'd1;
        cap_idx         = cnt[1:0] - 2'd1;

        unique case (state)
            IDLE: begin
                if (en_ls || if_req) begin
                    grant_ls     = en_ls && (!if_req || last_owner == OWN_IF);
                    owner_nxt    = grant_ls ? OWN_LS : OWN_IF;
                    is_read_nxt  = grant_ls ? (r_nw_in == READ_SIGNAL) : 1'b1;
                    base_nxt     = grant_ls ? ls_addr : if_addr;
                    nbytes_nxt   = grant_ls ? size_decode(ls_size) : 3'd4;
                    wdata_nxt    = ls_data_in;
                    cnt_nxt      = '0;
                    asm_nxt      = '0;
                    ram_addr_nxt = base_nxt;
                    ram_wr_nxt   = !is_read_nxt;
                    ram_dout_nxt = ls_data_in[7:0];
                    state_nxt    = XFER;
                end
            end
            XFER: begin
                if (is_read) begin
                    // RAM returns byte k one cycle late, so cnt runs to N and captures byte cnt-1
                    if (cnt != 3'd0) asm_nxt[{cap_idx, 3'b000} +: 8] = ram_din;
                    if (cnt == nbytes) begin
                        xfer_end = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc < nbytes) ram_addr_nxt = base + {29'd0, cnt_inc};
                    end
                end else begin
                    if (cnt == nbytes - 3'd1) begin
                        xfer_end = 1'b1;
                    end else begin
                        cnt_nxt      = cnt_inc;
                        ram_addr_nxt = base + {29'd0, cnt_inc};
                        ram_wr_nxt   = 1'b1;
                        ram_dout_nxt = wdata[{cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
                if (xfer_end) begin
                    state_nxt = DONE;
                    if (owner == OWN_LS) begin
                        finish_nxt      = 1'b1;
                        ls_data_out_nxt = asm_nxt;
                    end else begin
                        if_finish_nxt   = 1'b1;
                        if_data_nxt     = asm_nxt;
                    end
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                last_owner_nxt = owner;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_owner  <= OWN_IF;
            is_read     <= 1'b1;
            base        <= '0;
            nbytes      <= 3'd4;
            cnt         <= '0;
            wdata       <= '0;
            asm_q       <= '0;
            ram_addr    <= '0;
            ram_wr      <= 1'b0;
            ram_dout    <= '0;
            finish      <= 1'b0;
            if_finish   <= 1'b0;
            ls_data_out <= '0;
            if_data     <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_owner_nxt;
            is_read     <= is_read_nxt;
            base        <= base_nxt;
            nbytes      <= nbytes_nxt;
            cnt         <= cnt_nxt;
            wdata       <= wdata_nxt;
            asm_q       <= asm_nxt;
            ram_addr    <= ram_addr_nxt;
            ram_wr      <= ram_wr_nxt;
            ram_dout    <= ram_dout_nxt;
            finish      <= finish_nxt;
            if_finish   <= if_finish_nxt;
            ls_data_out <= ls_data_out_nxt;
            if_data     <= if_data_nxt;
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-port controller that shares the single byte-wide RAM port between instruction fetch and `ex_ls`. It accepts level-held requests and serialises each 1/2/4-byte access into byte cycles, little-endian. It returns a one-cycle completion pulse to the owner: `finish` to `ex_ls`, `if_finish` to fetch. It sits between the execute/fetch stages and the RAM.

## Interface
- No parameters; widths come from the global macros (`addr_t` = 32, `word_t`/`dword_t` = 32, `byte_t` = 8).
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held high until `if_finish` is seen
- if_addr  in  32  fetch address; always a 4-byte read
- if_finish  out  1  one-cycle completion pulse to fetch
- if_data  out  32  fetched word; valid while `if_finish`=1 and held afterwards
- en_ls  in  1  LS request from `ex_ls`, held high until `finish` is seen
- r_nw_in  in  1  `READ_SIGNAL`/`WRITE_SIGNAL`
- ls_addr  in  32  LS base address
- ls_size  in  8  byte count: 1, 2 or 4
- ls_data_in  in  32  store data; byte k = bits [8k+7:8k]
- finish  out  1  one-cycle completion pulse to `ex_ls`
- ls_data_out  out  32  load result, zero-extended; valid with `finish` and held afterwards
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  1 = write `ram_dout` at `ram_addr` this cycle
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; returns the byte addressed in the previous cycle (synchronous RAM, 1-cycle latency)

## Operation
- States:
  - IDLE: requests are sampled only here.
  - XFER: byte cycles.
  - DONE: completion pulse.
- Arbitration in IDLE:
  - Only one request pending → grant it.
  - Both pending → grant the requester not served last. `last_owner` resets to IF, so LS wins the first conflict.
- On grant:
  - Latch owner, direction (IF is always a read), base address, size N, and store data.
  - Clear byte counter `cnt` and the read-assembly register.
  - Go to XFER.
- ls_size decode: 1 → N=1, 2 → N=2, any other value → N=4.
- XFER, write:
  - Cycle k (k=0..N-1): ram_addr=base+k, ram_wr=1, ram_dout=store byte k.
  - After k=N-1 → DONE.
- XFER, read:
  - Cycle k (k=0..N-1): ram_addr=base+k, ram_wr=0.
  - ram_din in cycle k+1 is captured into result byte k.
  - One extra capture cycle follows k=N-1, with ram_addr holding base+N-1 and ram_wr=0.
  - Then → DONE.
- DONE:
  - Pulse `finish` (LS owner) or `if_finish` (IF owner) for exactly one cycle.
  - Copy the assembled result to ls_data_out/if_data. Unread upper bytes are 0.
  - Update `last_owner`; → IDLE.
- Address arithmetic is base+cnt mod 2^32, so 0xFFFF_FFFF+1 wraps to 0x0000_0000.
- Requests are not abortable. If the requester drops its request mid-XFER, the transfer still completes and the pulse is still issued. Stores are never partially performed, except by reset.
- Request inputs are ignored outside IDLE. Latched fields are immune to input changes after grant.
- ls_data_out/if_data change only in a DONE cycle of their own owner.

## Timing
- Reset values: if_finish=0, finish=0, ram_wr=0, ram_addr=0, ram_dout=0, ls_data_out=0, if_data=0; state=IDLE, cnt=0, last_owner=IF.
- Reset is asynchronous: assertion mid-transfer drops ram_wr and the pulses immediately and abandons the transfer.
- All outputs are driven from registers. There is no combinational path from request inputs to RAM outputs.
- Request high in IDLE cycle t0 → first byte cycle t0+1.
- Read of N bytes: finish/if_finish high in cycle t0+N+2 (LW/fetch: t0+6; LB: t0+3).
- Write of N bytes: finish high in cycle t0+N+1 (SW: t0+5; SB: t0+2).
- The cycle after DONE is IDLE, and a new grant can occur there (t_done+1). The requester has dropped its request at the same edge it sampled the pulse, so the completed request is not re-granted.
- Back-to-back conflicting requests alternate LS/IF.

## Test plan
- LW: en_ls=1, r_nw=READ, ls_addr=0x100, size=4; RAM[0x100..0x103]=11,22,33,44 → ram_addr 0x100..0x103 in t0+1..t0+4; finish=1 only at t0+6; ls_data_out=0x44332211.
- SH: ls_addr=0x200, size=2, ls_data_in=0xAABBCCDD → ram_wr=1 at t0+1 (0x200, 0xDD) and t0+2 (0x201, 0xCC); finish at t0+3; RAM[0x202] untouched.
- Conflict: if_req and en_ls both high from reset → LS granted first. After its finish, IF is granted; the next simultaneous conflict grants LS again. if_data=word at if_addr.
- Withdrawal: en_ls dropped at t0+2 of an SW → all 4 bytes written; finish still pulses at t0+5.
- Wrap plus odd size: LH at 0xFFFF_FFFF, size=3 treated as 4 → addresses FFFF_FFFF, 0, 1, 2 issued.
- Reset at t0+2 of an SW → ram_wr=0 immediately; no finish; controller is IDLE after release and accepts the next request normally.
